// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: FSM states, requester indices and parity helper shared by the
// RAM port arbiter and its round-robin picker.
package ram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
    localparam int PAR_MAX_W = 64;
    // Zero-extending a narrower payload into this width leaves its parity unchanged.
    function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction
endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector; on a contest the
// requester not granted last wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_any
);
    always_comb begin
        o_grant[REQ_A] = i_req[REQ_A] & (~i_req[REQ_B] | (i_last_grant == REQ_B));
        o_grant[REQ_B] = i_req[REQ_B] & (~i_req[REQ_A] | (i_last_grant == REQ_A));
        o_any = |i_req;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin sequencer for the single-port parity-tagged RAM.
// Define RAM_ARB_PARITY_CHK_EN to generate read parity checking on rsp_err.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [1:0]            i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_a,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_b,
    input  logic [DATA_WIDTH-1:0] i_req_wdata_a,
    input  logic [DATA_WIDTH-1:0] i_req_wdata_b,
    output logic [1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_din,
    output logic                  o_ram_we_n,
    input  logic [DATA_WIDTH:0]   i_ram_dout
);
    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic [1:0]            w_grant;
    logic                  w_any;
    logic                  w_win;
    logic [1:0]            r_req_ready;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic                  r_ram_we_n;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_op_we;

    rr_pick2 u_pick (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any        (w_any)
    );

    assign w_win = w_grant[REQ_B];

    always_comb begin
        w_next   = r_state;
        w_accept = (r_state == IDLE) && w_any;
        w_next   = (r_state == IDLE)   ? (w_any ? ACCESS : IDLE) :
                   (r_state == ACCESS) ? RESP : IDLE;
    end

    // last_grant always follows the winner: a repeat sole winner leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_ready  <= 2'b00;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_we_n   <= 1'b1;
            r_grant      <= REQ_A;
            r_last_grant <= REQ_B;
            r_op_we      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= w_accept ? w_grant : 2'b00;
            r_rsp_valid <= (r_state == RESP) ? ((r_grant == REQ_B) ? 2'b10 : 2'b01) : 2'b00;
            if (w_accept) begin
                r_ram_addr   <= w_win ? i_req_addr_b : i_req_addr_a;
                r_ram_din    <= w_win ? i_req_wdata_b : i_req_wdata_a;
                r_ram_we_n   <= ~i_req_we[w_win];
                r_grant      <= w_win;
                r_last_grant <= w_win;
                r_op_we      <= i_req_we[w_win];
            end else if (r_state == ACCESS) begin
                r_ram_we_n   <= 1'b1;
            end
            if (r_state == RESP)
                r_rsp_rdata <= i_ram_dout[DATA_WIDTH:1];
        end
    end

`ifdef RAM_ARB_PARITY_CHK_EN
    logic r_rsp_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rsp_err <= 1'b0;
        else if (r_state == RESP)
            r_rsp_err <= ~r_op_we & (parity_of(PAR_MAX_W'(i_ram_dout[DATA_WIDTH:1])) != i_ram_dout[0]);
    end
    assign o_rsp_err = r_rsp_err;
`else
    logic w_unused_par;
    assign w_unused_par = ^{i_ram_dout[0], r_op_we};
    assign o_rsp_err    = 1'b0;
`endif

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_din   = r_ram_din;
    assign o_ram_we_n  = r_ram_we_n;
endmodule
